dm_sba_wide: RTL

DM_SBA_WIDE -- requirements
Module: dm_sba_wide

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_sba_lane_align.sv | 36 +++
 rtl/dm_sba_wide.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types for the debug-module system bus access engine: FSM states and error codes.
package dm_pkg;

   typedef enum logic [2:0] {
      Idle,
      Read,
      Write,
      WaitRead,
      WaitWrite
   } sba_state_e;

   typedef enum logic [2:0] {
      None    = 3'd0,
      Timeout = 3'd1,
      BadAddr = 3'd2,
      Align   = 3'd3,
      Size    = 3'd4,
      Other   = 3'd7
   } sberr_e;

endpackage

// File: rtl/dm_sba_lane_align.sv
// Byte-lane steering for system bus accesses: byte enables, write-data replication
// and read-data shift/mask for an access of 2^sbaccess bytes at a given lane offset.
module dm_sba_lane_align #(
   parameter int BusWidth = 32
) (
   input  logic [$clog2(BusWidth/8)-1:0] offset_i,
   input  logic [2:0]                    sbaccess_i,
   input  logic [BusWidth-1:0]           sbdata_i,
   input  logic [BusWidth-1:0]           r_rdata_i,
   output logic [BusWidth/8-1:0]         be_o,
   output logic [BusWidth-1:0]           wdata_o,
   output logic [BusWidth-1:0]           rdata_o
);

   localparam int Lanes = BusWidth / 8;

   int                  size_bytes;
   int                  off;
   logic [BusWidth-1:0] shifted;

   always_comb begin
      size_bytes = 1 << sbaccess_i;
      off        = int'(offset_i);
      shifted    = r_rdata_i >> (8 * off);
      be_o       = '0;
      wdata_o    = '0;
      rdata_o    = '0;
      for (int i = 0; i < Lanes; i++) begin
         be_o[i]           = (i >= off) && (i < off + size_bytes);
         // Lane i carries byte (i mod size) of the write data, so every aligned slot sees the value.
         wdata_o[8*i +: 8] = sbdata_i[8*(i % size_bytes) +: 8];
         rdata_o[8*i +: 8] = (i < size_bytes) ? shifted[8*i +: 8] : 8'h00;
      end
   end

endmodule

// File: rtl/dm_sba_wide.sv
// System bus access engine for the debug module, BusWidth of 32/64/128 bits.
// Optional wait-state timeout is compiled in with the DM_SBA_TIMEOUT_EN macro.
module dm_sba_wide
   import dm_pkg::*;
#(
   parameter int BusWidth      = 32,
   parameter int TimeoutCycles = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [BusWidth-1:0]     sbaddress_i,
   output logic [BusWidth-1:0]     sbaddress_o,
   input  logic                    sbaddress_write_valid_i,
   input  logic                    sbreadonaddr_i,
   input  logic                    sbautoincrement_i,
   input  logic [2:0]              sbaccess_i,
   input  logic [BusWidth-1:0]     sbdata_i,
   input  logic                    sbdata_write_valid_i,
   input  logic                    sbdata_read_valid_i,
   input  logic                    sbreadondata_i,
   output logic [BusWidth-1:0]     sbdata_o,
   output logic                    sbdata_valid_o,
   output logic                    sbbusy_o,
   output logic                    sbbusyerror_o,
   output logic                    sberror_valid_o,
   output logic [2:0]              sberror_o,
   output logic                    req_o,
   output logic                    we_o,
   output logic [BusWidth-1:0]     add_o,
   output logic [BusWidth-1:0]     wdata_o,
   output logic [BusWidth/8-1:0]   be_o,
   input  logic                    gnt_i,
   input  logic                    r_valid_i,
   input  logic                    r_err_i,
   input  logic [BusWidth-1:0]     r_rdata_i
);

   localparam int Lanes    = BusWidth / 8;
   localparam int LaneBits = $clog2(Lanes);

   if (BusWidth != 32 && BusWidth != 64 && BusWidth != 128) begin : g_bad_width
      $error("dm_sba_wide: BusWidth must be 32, 64 or 128");
   end
   if (TimeoutCycles < 1) begin : g_bad_timeout
      $error("dm_sba_wide: TimeoutCycles must be at least 1");
   end

   sba_state_e          state_q;
   sberr_e              err_q;
   logic [BusWidth-1:0] addr_q;
   logic [BusWidth-1:0] rdata_q;
   logic                dvalid_q;
   logic                errv_q;
   logic                busyerr_q;

   logic                data_trig;
   logic                addr_trig;
   logic                size_bad;
   logic                align_bad;
   logic [BusWidth-1:0] eff_addr;
   logic [BusWidth-1:0] size_mask;
   logic [BusWidth-1:0] addr_inc;
   logic [Lanes-1:0]    lane_be;
   logic [BusWidth-1:0] lane_wdata;
   logic [BusWidth-1:0] lane_rdata;

`ifdef DM_SBA_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] tcnt_q;
`endif

   assign data_trig = sbdata_write_valid_i | (sbdata_read_valid_i & sbreadondata_i);
   assign addr_trig = sbaddress_write_valid_i & sbreadonaddr_i;

   // An address write in the same cycle as the trigger supplies the access address.
   assign eff_addr  = sbaddress_write_valid_i ? sbaddress_i : addr_q;
   assign size_bad  = sbaccess_i > 3'(LaneBits);
   assign size_mask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
   assign align_bad = |(eff_addr & size_mask);
   assign addr_inc  = addr_q + (BusWidth'(1) << sbaccess_i);

   dm_sba_lane_align #(
      .BusWidth (BusWidth)
   ) u_lane_align (
      .offset_i   (addr_q[LaneBits-1:0]),
      .sbaccess_i (sbaccess_i),
      .sbdata_i   (sbdata_i),
      .r_rdata_i  (r_rdata_i),
      .be_o       (lane_be),
      .wdata_o    (lane_wdata),
      .rdata_o    (lane_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= Idle;
         err_q     <= None;
         addr_q    <= '0;
         rdata_q   <= '0;
         dvalid_q  <= 1'b0;
         errv_q    <= 1'b0;
         busyerr_q <= 1'b0;
`ifdef DM_SBA_TIMEOUT_EN
         tcnt_q    <= '0;
`endif
      end else begin
         dvalid_q  <= 1'b0;
         errv_q    <= 1'b0;
         err_q     <= None;
         busyerr_q <= (state_q != Idle) && data_trig;
         if (sbaddress_write_valid_i) addr_q <= sbaddress_i;

         case (state_q)
            Idle: begin
`ifdef DM_SBA_TIMEOUT_EN
               tcnt_q <= '0;
`endif
               if (data_trig || addr_trig) begin
                  if (size_bad) begin
                     errv_q <= 1'b1;
                     err_q  <= Size;
                  end else if (align_bad) begin
                     errv_q <= 1'b1;
                     err_q  <= Align;
                  end else if (sbdata_write_valid_i) begin
                     state_q <= Write;
                  end else begin
                     state_q <= Read;
                  end
               end
            end
            Read:  if (gnt_i) state_q <= WaitRead;
            Write: if (gnt_i) state_q <= WaitWrite;
            WaitRead, WaitWrite: begin
               if (r_valid_i) begin
                  state_q <= Idle;
                  if (r_err_i) begin
                     errv_q <= 1'b1;
                     err_q  <= BadAddr;
                  end else begin
                     if (state_q == WaitRead) begin
                        rdata_q  <= lane_rdata;
                        dvalid_q <= 1'b1;
                     end
                     // A fresh address from the DM takes precedence over the increment.
                     if (sbautoincrement_i && !sbaddress_write_valid_i) addr_q <= addr_inc;
                  end
               end
`ifdef DM_SBA_TIMEOUT_EN
               else if (tcnt_q == CntW'(TimeoutCycles - 1)) begin
                  state_q <= Idle;
                  errv_q  <= 1'b1;
                  err_q   <= Timeout;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= Idle;
         endcase
      end
   end

   assign req_o           = (state_q == Read) || (state_q == Write);
   assign we_o            = (state_q == Write);
   assign sbbusy_o        = (state_q != Idle);
   assign add_o           = addr_q;
   assign sbaddress_o     = addr_q;
   assign be_o            = req_o ? lane_be : '0;
   assign wdata_o         = req_o ? lane_wdata : '0;
   assign sbdata_o        = rdata_q;
   assign sbdata_valid_o  = dvalid_q;
   assign sberror_valid_o = errv_q;
   assign sberror_o       = err_q;
   assign sbbusyerror_o   = busyerr_q;

endmodule
